// File: rtl/jtdd_irqctl.sv
// jtdd_irqctl: parametrised 6809 interrupt controller.
// Edge/level capture, pending latch, mask, routing to nNMI/nFIRQ/nIRQ.
//
// Ports:
//   clk, rstn        clock, async active-low reset
//   cen              CPU clock enable, qualifies register writes
//   irq_in[CH]       raw interrupt sources
//   clr[CH]          hardware clear strobes from the address decoder
//   pause            blocks capture on PAUSE_MSK channels
//   cs/addr/rnw/din  CPU register port
//   dout             read data, 8'hFF when not selected
//   pending[CH]      pending bits
//   nIRQ/nFIRQ/nNMI  registered active-low interrupt lines
module jtdd_irqctl #(
    parameter int          CH        = 3,
    parameter logic [7:0]  EDGE      = 8'hFF,
    parameter logic [7:0]  POL       = 8'hFF,
    parameter logic [15:0] ROUTE     = 16'h0024,
    parameter logic [7:0]  MASK_RST  = 8'hFF,
    parameter logic [7:0]  PAUSE_MSK = 8'h04,
    parameter bit          SYNC      = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen,
    input  logic [CH-1:0] irq_in,
    input  logic [CH-1:0] clr,
    input  logic          pause,
    input  logic          cs,
    input  logic [1:0]    addr,
    input  logic          rnw,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CH-1:0] pending,
    output logic          nIRQ,
    output logic          nFIRQ,
    output logic          nNMI
);

    localparam logic [CH-1:0] EDGE_C = EDGE[CH-1:0];
    localparam logic [CH-1:0] POL_C  = POL[CH-1:0];
    localparam logic [CH-1:0] PMSK_C = PAUSE_MSK[CH-1:0];
    localparam logic [CH-1:0] MRST_C = MASK_RST[CH-1:0];

    function automatic logic [CH-1:0] route_sel(input logic [1:0] code);
        logic [CH-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++)
            r[i] = (ROUTE[2*i +: 2] == code);
        return r;
    endfunction

    localparam logic [CH-1:0] RT_IRQ  = route_sel(2'd0);
    localparam logic [CH-1:0] RT_FIRQ = route_sel(2'd1);
    localparam logic [CH-1:0] RT_NMI  = route_sel(2'd2);

    logic [CH-1:0] raw_a;
    logic [CH-1:0] a;

    // Synchroniser works on the raw pin level, so it idles at ~POL.
    if (SYNC) begin : g_sync
        logic [CH-1:0] s1_q, s2_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s1_q <= ~POL_C;
                s2_q <= ~POL_C;
            end else begin
                s1_q <= irq_in;
                s2_q <= s1_q;
            end
        end
        assign raw_a = s2_q;
    end else begin : g_nosync
        assign raw_a = irq_in;
    end

    // Normalise to active high.
    assign a = raw_a ^ ~POL_C;

    logic          wr;
    logic [CH-1:0] wclr;
    logic [CH-1:0] blk;
    logic [CH-1:0] evt;
    logic [CH-1:0] h_q;
    logic [CH-1:0] pend_q, pend_d;
    logic [CH-1:0] mask_q, mask_d;
    logic          nirq_q, nfirq_q, nnmi_q;
    logic [CH-1:0] act;

    assign wr   = cs & ~rnw & cen;
    assign wclr = (wr && addr == 2'd1) ? din[CH-1:0] : '0;
    assign blk  = {CH{pause}} & PMSK_C;
    assign evt  = a & ~h_q & ~blk;

    // Edge: new event beats any clear in the same cycle.
    // Level: pending simply follows the qualified input.
    assign pend_d = (EDGE_C & ((pend_q & ~(clr | wclr)) | evt))
                  | (~EDGE_C & a & ~blk);

    assign mask_d = (wr && addr == 2'd0) ? din[CH-1:0] : mask_q;

    assign act = pend_q & mask_q;

    // History is kept normalised, so the inactive level is 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_q     <= '0;
            pend_q  <= '0;
            mask_q  <= MRST_C;
            nirq_q  <= 1'b1;
            nfirq_q <= 1'b1;
            nnmi_q  <= 1'b1;
        end else begin
            h_q     <= a;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            nirq_q  <= ~|(act & RT_IRQ);
            nfirq_q <= ~|(act & RT_FIRQ);
            nnmi_q  <= ~|(act & RT_NMI);
        end
    end

    logic [7:0] rd;

    always_comb begin
        rd = 8'h00;
        unique case (addr)
            2'd0: rd[CH-1:0] = mask_q;
            2'd1: rd[CH-1:0] = pend_q;
            2'd2: rd[CH-1:0] = a;
            2'd3: rd = 8'(CH - 1);
            default: rd = 8'h00;
        endcase
    end

    logic unused_din;
    assign unused_din = ^din;

    assign dout    = cs ? rd : 8'hFF;
    assign pending = pend_q;
    assign nIRQ    = nirq_q;
    assign nFIRQ   = nfirq_q;
    assign nNMI    = nnmi_q;

endmodule
